alu_issue_arbiter: RTL and testbench
====================================

// Module: alu_issue_arbiter
// PURPOSE
//  Shares the single 64-bit ALU between two requesters: 0 = integer pipe, 1 = FP pipe.
//  Arbitrates issue, registers and holds the operands, and drives the ALU operation code.
//  Counts the per-op occupancy, then captures the ALU result and returns it with a requester id.
//  Sits in EX, between the ID/EX issue logic and the combinational ALU.
// PARAMETERS
//  LAT_FPS  2  cycles held for op 5'h0C (FP add single)
//  LAT_FPD  3  cycles held for op 5'h0D (FP add double)
//  LAT_MUL  4  cycles held for op 5'h0F (multiply)
//  LAT_DIV  8  cycles held for op 5'h10 (divide); all other ops hold 1 cycle; every LAT_* >= 1
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   asynchronous reset, active low
//  reqN_valid  in   1   requester N (N=0,1) has an op
//  reqN_ready  out  1   requester N op accepted this cycle (valid & ready)
//  reqN_op     in   5   ALU operation code
//  reqN_a      in   64  Op1 (rs/ft)
//  reqN_b      in   64  Op2 (imm/rt/fs)
//  reqN_shamt  in   5   shift amount
//  alu_op      out  5   to ALU operation
//  alu_op1     out  64  to ALU Op1
//  alu_op2     out  64  to ALU Op2
//  alu_shamt   out  5   to ALU shamt
//  alu_result  in   64  from ALU EXE_Result
//  alu_zero    in   1   from ALU EXE_Zero
//  alu_ovf     in   1   from ALU Overflow
//  rsp_valid   out  1   response held
//  rsp_ready   in   1   consumer accepts response
//  rsp_id      out  1   requester that issued the op
//  rsp_result  out  64  captured result
//  rsp_zero    out  1   captured zero/compare flag
//  rsp_ovf     out  1   captured overflow
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer = requester 0 preferred; counter 0.
//   Reset mid-op discards the in-flight op and any held response.
//  FSM IDLE -> BUSY -> DONE.
//   IDLE: alu_op = 5'h00 (no-op); alu_op1/alu_op2/alu_shamt = 0.
//   BUSY: registered op/operands drive the ALU unchanged; cnt loads LAT(op)-1 on accept, decrements each cycle.
//   BUSY, cnt==0: next edge captures alu_result/zero/ovf into rsp_*; rsp_valid=1; -> DONE.
//   DONE: alu_op returns to 5'h00; rsp_* held stable until rsp_valid & rsp_ready.
//  Latency: accept at edge N -> rsp_valid high after edge N+LAT.
//  Accept window: reqN_ready = grant_N & (IDLE | (DONE & rsp_ready)).
//   Back-to-back accept in the same cycle a response retires: -> BUSY, rsp_valid drops.
//   Otherwise a retired response goes -> IDLE.
//  reqN_ready is combinational on reqN_valid and state; it never depends on reqN_op.
//  Arbitration: round robin over two requesters.
//   Both valid: grant the non-pointer side? No -- grant the pointer side; after an accept, pointer = other id.
//   Only one valid: that one is granted; pointer still toggles to the side not just served.
//  Ops not in the latency table (including 5'h00 and 5'h17-5'h1F) hold 1 cycle; no error signalled.
//  Simultaneous rsp_ready with no pending op: ignored.
// CONFIGURATION
//  ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins when both are valid; pointer logic removed.
//  ALU_ARB_FIXED_PRIO_EN undefined (default): round robin as above.
// STRUCTURE
//  alu_pkg (shared package):
//   localparams for op codes: OP_FPADD_S=5'h0C, OP_FPADD_D=5'h0D, OP_MUL=5'h0F, OP_DIV=5'h10, OP_NOP=5'h00.
//   FSM state typedef.
//   Function op_latency(op) returning 4 bits, fed by the LAT_* parameters.
//  Sub-module alu_rr_arbiter: 2-way grant with pointer, macro-controlled; no datapath.
//  Top: operand register, counter, FSM, response register.
// TESTING
//  req0 op 5'h03 a=5 b=7, rsp_ready=1 -> rsp_valid 1 cycle after accept; rsp_id=0; rsp_result=12.
//  req1 op 5'h0F a=3 b=4 -> alu_op=5'h0F stable 4 cycles; rsp_result=12 at accept+4; req0 ready=0 meanwhile.
//  Both valid every cycle, rsp_ready=1, op 5'h02 -> grants alternate 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN, all grants go to 0.
//  rsp_ready=0 for 5 cycles after op 5'h10 a=20 b=6 -> rsp_result={32'd2,32'd3} held stable; both reqN_ready=0 until retire.
//  rst_n low 2 cycles into op 5'h0D -> all outputs 0 asynchronously; after release, the first accept still works and LAT=3 holds.
//  rsp_ready=1 in DONE with req1 valid -> req1_ready=1 in the same cycle; rsp_valid drops the next cycle; state BUSY.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the EX-stage ALU issue arbiter.
//   - Operation codes that carry a multi-cycle occupancy.
//   - FSM state type for the issue/hold/response sequence.
//   - op_latency(): occupancy in cycles for a given op, taken from the
//     LAT_* values of the instantiating module.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [4:0] OP_NOP     = 5'h00;
    localparam logic [4:0] OP_FPADD_S = 5'h0C;
    localparam logic [4:0] OP_FPADD_D = 5'h0D;
    localparam logic [4:0] OP_MUL     = 5'h0F;
    localparam logic [4:0] OP_DIV     = 5'h10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    // Any op outside the table, including NOP and the unused codes, is a
    // single-cycle op; unknown codes are not flagged.
    function automatic logic [3:0] op_latency(
        input logic [4:0] op,
        input logic [3:0] lat_fps,
        input logic [3:0] lat_fpd,
        input logic [3:0] lat_mul,
        input logic [3:0] lat_div
    );
        case (op)
            OP_FPADD_S: op_latency = lat_fps;
            OP_FPADD_D: op_latency = lat_fpd;
            OP_MUL:     op_latency = lat_mul;
            OP_DIV:     op_latency = lat_div;
            default:    op_latency = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
// Two-way grant logic for the shared ALU. No datapath.
// Configuration macro: ALU_ARB_FIXED_PRIO_EN
//   defined   -> requester 0 always wins a tie, no pointer state.
//   undefined -> round robin: a tie goes to the pointer side, and after every
//                accept the pointer moves to the side that was not served.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   valid0_i    requester 0 has an op
//   valid1_i    requester 1 has an op
//   accept_i    an op was accepted this cycle (handshake completed)
//   grant0_o    requester 0 would be accepted if the window is open
//   grant1_o    requester 1 would be accepted if the window is open
// -----------------------------------------------------------------------------
module alu_rr_arbiter (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic accept_i,
    output logic grant0_o,
    output logic grant1_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN

    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, accept_i};

    assign grant0_o = valid0_i;
    assign grant1_o = valid1_i & ~valid0_i;

`else

    // ptr_q = 0 prefers requester 0, 1 prefers requester 1.
    logic ptr_q;
    logic ptr_d;

    assign grant0_o = valid0_i & (~valid1_i | ~ptr_q);
    assign grant1_o = valid1_i & (~valid0_i | ptr_q);

    // Serving requester 0 hands preference to 1, and vice versa.
    assign ptr_d = accept_i ? grant0_o : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule

// File: rtl/alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter
// Shares the single 64-bit combinational ALU between the integer pipe (id 0)
// and the FP pipe (id 1). An accepted op is registered and held on the ALU
// for its occupancy, then the ALU result is captured and held until the
// consumer takes it.
// Configuration macro: ALU_ARB_FIXED_PRIO_EN (see alu_rr_arbiter).
// Ports:
//   clk, rst_n                     clock / asynchronous active-low reset
//   reqN_valid/_ready              issue handshake for requester N (0,1)
//   reqN_op/_a/_b/_shamt           op code, operands and shift amount
//   alu_op/_op1/_op2/_shamt        registered drive to the ALU
//   alu_result/_zero/_ovf          combinational ALU outputs
//   rsp_valid/_ready               response handshake
//   rsp_id/_result/_zero/_ovf      captured response and issuing requester
// -----------------------------------------------------------------------------
module alu_issue_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned LAT_FPS = 2,
    parameter int unsigned LAT_FPD = 3,
    parameter int unsigned LAT_MUL = 4,
    parameter int unsigned LAT_DIV = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_op,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic [4:0]  req0_shamt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_op,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic [4:0]  req1_shamt,
    output logic [4:0]  alu_op,
    output logic [63:0] alu_op1,
    output logic [63:0] alu_op2,
    output logic [4:0]  alu_shamt,
    input  logic [63:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_ovf,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_ovf
);

    arb_state_e  state_q;
    logic [3:0]  cnt_q;
    logic        issue_id_q;
    logic [4:0]  alu_op_q;
    logic [63:0] alu_op1_q;
    logic [63:0] alu_op2_q;
    logic [4:0]  alu_shamt_q;
    logic        rsp_valid_q;
    logic        rsp_id_q;
    logic [63:0] rsp_result_q;
    logic        rsp_zero_q;
    logic        rsp_ovf_q;

    logic        grant0;
    logic        grant1;
    logic        window_open;
    logic        accept;
    logic [4:0]  sel_op_d;
    logic [63:0] sel_a_d;
    logic [63:0] sel_b_d;
    logic [4:0]  sel_shamt_d;
    logic [3:0]  sel_cnt_d;

    alu_rr_arbiter u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .accept_i (accept),
        .grant0_o (grant0),
        .grant1_o (grant1)
    );

    // A new op can enter when idle, or in the same cycle the held response
    // retires. Ready depends only on valids and state, never on the op.
    assign window_open = (state_q == ST_IDLE) | ((state_q == ST_DONE) & rsp_ready);
    assign req0_ready  = grant0 & window_open;
    assign req1_ready  = grant1 & window_open;
    assign accept      = req0_ready | req1_ready;

    assign sel_op_d    = req1_ready ? req1_op    : req0_op;
    assign sel_a_d     = req1_ready ? req1_a     : req0_a;
    assign sel_b_d     = req1_ready ? req1_b     : req0_b;
    assign sel_shamt_d = req1_ready ? req1_shamt : req0_shamt;
    // The counter holds "cycles remaining after this one", so it starts at LAT-1.
    assign sel_cnt_d   = op_latency(sel_op_d, 4'(LAT_FPS), 4'(LAT_FPD),
                                    4'(LAT_MUL), 4'(LAT_DIV)) - 4'd1;

    // Issue/hold/response FSM with all outputs registered. The accept load
    // sits after the case so a back-to-back accept in DONE overrides the
    // return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            issue_id_q   <= 1'b0;
            alu_op_q     <= OP_NOP;
            alu_op1_q    <= 64'd0;
            alu_op2_q    <= 64'd0;
            alu_shamt_q  <= 5'd0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 64'd0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_BUSY: begin
                    if (cnt_q == 4'd0) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_id_q     <= issue_id_q;
                        rsp_result_q <= alu_result;
                        rsp_zero_q   <= alu_zero;
                        rsp_ovf_q    <= alu_ovf;
                        alu_op_q     <= OP_NOP;
                        alu_op1_q    <= 64'd0;
                        alu_op2_q    <= 64'd0;
                        alu_shamt_q  <= 5'd0;
                        state_q      <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (accept) begin
                state_q     <= ST_BUSY;
                cnt_q       <= sel_cnt_d;
                issue_id_q  <= req1_ready;
                alu_op_q    <= sel_op_d;
                alu_op1_q   <= sel_a_d;
                alu_op2_q   <= sel_b_d;
                alu_shamt_q <= sel_shamt_d;
            end
        end
    end

    assign alu_op     = alu_op_q;
    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;
    assign alu_shamt  = alu_shamt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_ovf    = rsp_ovf_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_arbiter
// Directed bench for alu_issue_arbiter with a small behavioural ALU attached.
// Honours ALU_ARB_FIXED_PRIO_EN for the arbitration expectations.
// -----------------------------------------------------------------------------
module tb_alu_issue_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_op, req1_op;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [4:0]  alu_op;
    logic [63:0] alu_op1, alu_op2;
    logic [4:0]  alu_shamt;
    logic [63:0] alu_result;
    logic        alu_zero, alu_ovf;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [63:0] rsp_result;
    logic        rsp_zero, rsp_ovf;

    int checks = 0;
    int errors = 0;

    alu_issue_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_shamt (req0_shamt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_shamt (req1_shamt),
        .alu_op     (alu_op),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_shamt  (alu_shamt),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_ovf    (alu_ovf),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_ovf    (rsp_ovf)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: adds for the add-like codes, multiply, and a divide
    // that packs {remainder, quotient} of the low words.
    always_comb begin
        alu_result = 64'd0;
        case (alu_op)
            5'h02, 5'h03, 5'h0C, 5'h0D: alu_result = alu_op1 + alu_op2;
            5'h0F: alu_result = alu_op1 * alu_op2;
            5'h10: begin
                if (alu_op2[31:0] != 32'd0) begin
                    alu_result = {alu_op1[31:0] % alu_op2[31:0], alu_op1[31:0] / alu_op2[31:0]};
                end
            end
            default: alu_result = 64'd0;
        endcase
        alu_zero = (alu_result == 64'd0);
        alu_ovf  = 1'b0;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int id, input logic valid, input logic [4:0] op,
                                 input logic [63:0] a, input logic [63:0] b, input logic [4:0] shamt);
        if (id == 0) begin
            req0_valid = valid; req0_op = op; req0_a = a; req0_b = b; req0_shamt = shamt;
        end else begin
            req1_valid = valid; req1_op = op; req1_a = a; req1_b = b; req1_shamt = shamt;
        end
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] divExp;
        logic        expId;
        divExp = {32'd2, 32'd3};

        // Reset values.
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        applyStimulus(0, 1'b0, 5'h00, 64'd0, 64'd0, 5'd0);
        applyStimulus(1, 1'b0, 5'h00, 64'd0, 64'd0, 5'd0);
        @(negedge clk); #1;
        checkOutput("reset_alu_op", alu_op, 5'h00);
        checkOutput("reset_alu_op1", alu_op1, 64'd0);
        checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
        checkOutput("reset_rsp_result", rsp_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle add from requester 0.
        rsp_ready = 1'b1;
        applyStimulus(0, 1'b1, 5'h03, 64'd5, 64'd7, 5'd3);
        #1;
        checkOutput("t1_req0_ready", req0_ready, 1'b1);
        checkOutput("t1_req1_ready", req1_ready, 1'b0);
        @(negedge clk);
        applyStimulus(0, 1'b0, 5'h00, 64'd0, 64'd0, 5'd0);
        #1;
        checkOutput("t1_alu_op", alu_op, 5'h03);
        checkOutput("t1_alu_op1", alu_op1, 64'd5);
        checkOutput("t1_alu_op2", alu_op2, 64'd7);
        checkOutput("t1_alu_shamt", alu_shamt, 5'd3);
        checkOutput("t1_rsp_valid_early", rsp_valid, 1'b0);
        @(negedge clk); #1;
        checkOutput("t1_rsp_valid", rsp_valid, 1'b1);
        checkOutput("t1_rsp_id", rsp_id, 1'b0);
        checkOutput("t1_rsp_result", rsp_result, 64'd12);
        checkOutput("t1_alu_op_done", alu_op, 5'h00);
        @(negedge clk); #1;
        checkOutput("t1_rsp_retired", rsp_valid, 1'b0);

        // Multiply from requester 1, requester 0 blocked while it runs,
        // then requester 0 accepted back-to-back as the response retires.
        applyStimulus(1, 1'b1, 5'h0F, 64'd3, 64'd4, 5'd0);
        #1;
        checkOutput("t2_req1_ready", req1_ready, 1'b1);
        @(negedge clk);
        applyStimulus(1, 1'b0, 5'h00, 64'd0, 64'd0, 5'd0);
        applyStimulus(0, 1'b1, 5'h02, 64'd1, 64'd1, 5'd0);
        #1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_alu_op_hold", alu_op, 5'h0F);
            checkOutput("t2_req0_blocked", req0_ready, 1'b0);
            checkOutput("t2_rsp_valid_early", rsp_valid, 1'b0);
            @(negedge clk); #1;
        end
        checkOutput("t2_rsp_valid", rsp_valid, 1'b1);
        checkOutput("t2_rsp_result", rsp_result, 64'd12);
        checkOutput("t2_rsp_id", rsp_id, 1'b1);
        checkOutput("t2_b2b_req0_ready", req0_ready, 1'b1);
        @(negedge clk);
        applyStimulus(0, 1'b0, 5'h00, 64'd0, 64'd0, 5'd0);
        #1;
        checkOutput("t2_b2b_rsp_drop", rsp_valid, 1'b0);
        checkOutput("t2_b2b_alu_op", alu_op, 5'h02);
        @(negedge clk); #1;
        checkOutput("t2_b2b_rsp_valid", rsp_valid, 1'b1);
        checkOutput("t2_b2b_rsp_result", rsp_result, 64'd2);
        checkOutput("t2_b2b_rsp_id", rsp_id, 1'b0);
        @(negedge clk); #1;

        // Both requesters valid every cycle: alternating grants from a
        // freshly reset pointer (or all to 0 with fixed priority).
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1'b1, 5'h02, 64'd1, 64'd1, 5'd0);
        applyStimulus(1, 1'b1, 5'h02, 64'd10, 64'd10, 5'd0);
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            expId = 1'b0;
`else
            expId = (k % 2 == 1);
`endif
            for (int w = 0; w < 6 && rsp_valid !== 1'b1; w++) begin
                @(negedge clk); #1;
            end
            checkOutput("t3_rsp_valid_wait", rsp_valid, 1'b1);
            checkOutput("t3_rr_id", rsp_id, expId);
            checkOutput("t3_rr_result", rsp_result, expId ? 64'd20 : 64'd2);
            if (k == 3) begin
                applyStimulus(0, 1'b0, 5'h00, 64'd0, 64'd0, 5'd0);
                applyStimulus(1, 1'b0, 5'h00, 64'd0, 64'd0, 5'd0);
            end
            @(negedge clk); #1;
        end
        checkOutput("t3_drained", rsp_valid, 1'b0);

        // Divide with the consumer stalled: response held, issue blocked.
        rsp_ready = 1'b0;
        applyStimulus(0, 1'b1, 5'h10, 64'd20, 64'd6, 5'd0);
        #1;
        checkOutput("t4_req0_ready", req0_ready, 1'b1);
        @(negedge clk);
        applyStimulus(0, 1'b1, 5'h03, 64'd1, 64'd1, 5'd0);
        applyStimulus(1, 1'b1, 5'h03, 64'd100, 64'd1, 5'd0);
        #1;
        checkOutput("t4_busy_alu_op", alu_op, 5'h10);
        repeat (7) @(negedge clk);
        #1;
        checkOutput("t4_rsp_valid_early", rsp_valid, 1'b0);
        @(negedge clk); #1;
        checkOutput("t4_rsp_valid", rsp_valid, 1'b1);
        checkOutput("t4_alu_op_done", alu_op, 5'h00);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t4_hold_result", rsp_result, divExp);
            checkOutput("t4_hold_valid", rsp_valid, 1'b1);
            checkOutput("t4_hold_req0_ready", req0_ready, 1'b0);
            checkOutput("t4_hold_req1_ready", req1_ready, 1'b0);
            @(negedge clk); #1;
        end
        // Retire with only requester 1 valid: it is accepted in the same cycle.
        applyStimulus(0, 1'b0, 5'h00, 64'd0, 64'd0, 5'd0);
        rsp_ready = 1'b1;
        #1;
        checkOutput("t4_retire_req1_ready", req1_ready, 1'b1);
        checkOutput("t4_retire_req0_ready", req0_ready, 1'b0);
        @(negedge clk);
        applyStimulus(1, 1'b0, 5'h00, 64'd0, 64'd0, 5'd0);
        #1;
        checkOutput("t4_b2b_rsp_drop", rsp_valid, 1'b0);
        checkOutput("t4_b2b_alu_op", alu_op, 5'h03);
        checkOutput("t4_b2b_alu_op1", alu_op1, 64'd100);
        @(negedge clk); #1;
        checkOutput("t4_b2b_rsp_valid", rsp_valid, 1'b1);
        checkOutput("t4_b2b_rsp_id", rsp_id, 1'b1);
        checkOutput("t4_b2b_rsp_result", rsp_result, 64'd101);
        @(negedge clk); #1;

        // Reset in the middle of an FP-double op, then a clean FP-double op.
        applyStimulus(0, 1'b1, 5'h0D, 64'd1, 64'd2, 5'd0);
        #1;
        checkOutput("t5_req0_ready", req0_ready, 1'b1);
        @(negedge clk);
        applyStimulus(0, 1'b0, 5'h00, 64'd0, 64'd0, 5'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_alu_op", alu_op, 5'h00);
        checkOutput("t5_rst_alu_op1", alu_op1, 64'd0);
        checkOutput("t5_rst_rsp_valid", rsp_valid, 1'b0);
        checkOutput("t5_rst_rsp_result", rsp_result, 64'd0);
        checkOutput("t5_rst_rsp_id", rsp_id, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 1'b1, 5'h0D, 64'd7, 64'd8, 5'd0);
        #1;
        checkOutput("t5_req1_ready", req1_ready, 1'b1);
        @(negedge clk);
        applyStimulus(1, 1'b0, 5'h00, 64'd0, 64'd0, 5'd0);
        #1;
        checkOutput("t5_alu_op", alu_op, 5'h0D);
        checkOutput("t5_rsp_valid_n0", rsp_valid, 1'b0);
        @(negedge clk); #1;
        checkOutput("t5_rsp_valid_n1", rsp_valid, 1'b0);
        @(negedge clk); #1;
        checkOutput("t5_rsp_valid_n2", rsp_valid, 1'b0);
        @(negedge clk); #1;
        checkOutput("t5_rsp_valid_n3", rsp_valid, 1'b1);
        checkOutput("t5_rsp_result", rsp_result, 64'd15);
        checkOutput("t5_rsp_id", rsp_id, 1'b1);
        @(negedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
